pipe_proc_core: RTL and testbench

Parametrised three-stage (IF, ID, EX/WB) in-order core that replaces the fixed 8-bit LI/ADD/JMP pipeline.
- Data width, register count and PC width are generic.
- Adds a SUB opcode.
- Fully synchronous on posedge clk; no event-triggered flushes.
- Fetch uses an external instruction-memory port with a valid qualifier.
- A writeback observation port drives the verification bench.

---
 rtl/pp_pkg.sv | 64 ++++++
 rtl/pp_regfile.sv | 39 +++
 rtl/pipe_proc_core.sv | 167 ++++++++++++++++
 tb/tb_pipe_proc_core.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_pkg.sv
// pp_pkg: shared definitions for the pipe_proc_core slice.
//   - opcode encodings (OP_LI / OP_ADD / OP_SUB / OP_JMP)
//   - instruction field-slice helpers parametrised on RA (register address width)
//   - sign-extension helper parametrised on the source field width
//   - field-width helpers for the IF/ID and ID/EX pipeline registers
// Helpers work on a MAX_W-bit container so any configuration with
// IW, DW and PAW no wider than MAX_W can share them.
package pp_pkg;

    localparam logic [1:0] OP_LI  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    localparam int OP_W  = 2;
    localparam int MAX_W = 32;

    // Instruction width for a given register-address width.
    function automatic int instr_w(input int ra);
        return OP_W + 2 * ra;
    endfunction

    // IF/ID register: {instr, pc, valid}.
    function automatic int if_id_w(input int ra, input int paw);
        return instr_w(ra) + paw + 1;
    endfunction

    // ID/EX register: {op, rd, opA, opB, valid}.
    function automatic int id_ex_w(input int ra, input int dw);
        return OP_W + ra + 2 * dw + 1;
    endfunction

    function automatic logic [MAX_W-1:0] low_mask(input int bits);
        return (MAX_W'(1) << bits) - MAX_W'(1);
    endfunction

    function automatic logic [1:0] f_op(input logic [MAX_W-1:0] instr, input int ra);
        return instr[2*ra +: 2];
    endfunction

    function automatic logic [MAX_W-1:0] f_rd(input logic [MAX_W-1:0] instr, input int ra);
        return (instr >> ra) & low_mask(ra);
    endfunction

    // rs and the LI immediate share the same field.
    function automatic logic [MAX_W-1:0] f_rs(input logic [MAX_W-1:0] instr, input int ra);
        return instr & low_mask(ra);
    endfunction

    function automatic logic [MAX_W-1:0] f_off(input logic [MAX_W-1:0] instr, input int ra);
        return instr & low_mask(2 * ra);
    endfunction

    // Sign-extend the low 'bits' bits of v to MAX_W bits.
    function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int bits);
        logic [MAX_W-1:0] r;
        r = v;
        for (int i = 0; i < MAX_W; i++) begin
            if (i >= bits) r[i] = v[bits-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/pp_regfile.sv
// pp_regfile: RN x DW architectural register file.
//   clk_i, reset_i     : clock / asynchronous active-high reset (all regs -> 0)
//   raddr_a_i, rdata_a_o : combinational read port A
//   raddr_b_i, rdata_b_o : combinational read port B
//   we_i, waddr_i, wdata_i : synchronous write port
// Reads return the stored value only; forwarding of the in-flight write
// is handled by the core.
module pp_regfile
    import pp_pkg::*;
#(
    parameter int DW = 8,
    parameter int RN = 8,
    localparam int RA = $clog2(RN)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [RA-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [RA-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o,
    input  logic          we_i,
    input  logic [RA-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    logic [DW-1:0] regs_q [RN];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < RN; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/pipe_proc_core.sv
// pipe_proc_core: three-stage (IF, ID, EX/WB) in-order LI/ADD/SUB/JMP core.
//   clk        : clock, all state on rising edge
//   reset      : asynchronous, active-high
//   imem_addr  : fetch address (= pc)
//   imem_data  : instruction at imem_addr, same cycle
//   imem_valid : imem_data usable this cycle (0 = fetch stall)
//   wb_valid   : EX writes a register at the coming edge
//   wb_addr    : destination register
//   wb_data    : value written
// Build option: define SAT_ARITH_EN to make ADD/SUB saturate as signed
// DW-bit values; otherwise they wrap modulo 2^DW.
module pipe_proc_core
    import pp_pkg::*;
#(
    parameter int DW  = 8,
    parameter int RN  = 8,
    parameter int PAW = 8,
    localparam int RA = $clog2(RN),
    localparam int IW = 2 + 2 * RA
) (
    input  logic           clk,
    input  logic           reset,
    output logic [PAW-1:0] imem_addr,
    input  logic [IW-1:0]  imem_data,
    input  logic           imem_valid,
    output logic           wb_valid,
    output logic [RA-1:0]  wb_addr,
    output logic [DW-1:0]  wb_data
);

`ifdef SAT_ARITH_EN
    // Clamp a DW+1-bit signed result into the signed DW-bit range.
    function automatic logic [DW-1:0] sat_fn(input logic signed [DW:0] v);
        if (v[DW] != v[DW-1]) begin
            return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
        return v[DW-1:0];
    endfunction
`endif

    function automatic logic [DW-1:0] alu_fn(input logic [1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic signed [DW:0] wide;
        logic [DW-1:0] res;
        wide = '0;
        res  = b;
        if (op == OP_ADD || op == OP_SUB) begin
            if (op == OP_ADD) wide = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
            else              wide = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
`ifdef SAT_ARITH_EN
            res = sat_fn(wide);
`else
            res = wide[DW-1:0];
`endif
        end
        return res;
    endfunction

    // IF state and IF/ID register
    logic [PAW-1:0] pc_q, pc_d;
    logic [IW-1:0]  ifid_instr_q, ifid_instr_d;
    logic [PAW-1:0] ifid_pc_q, ifid_pc_d;
    logic           ifid_vld_q, ifid_vld_d;

    // ID/EX register
    logic [1:0]     idex_op_q, idex_op_d;
    logic [RA-1:0]  idex_rd_q, idex_rd_d;
    logic [DW-1:0]  idex_a_q, idex_a_d;
    logic [DW-1:0]  idex_b_q, idex_b_d;
    logic           idex_vld_q, idex_vld_d;

    // ID decode
    logic [MAX_W-1:0] instr_x;
    logic [1:0]       id_op;
    logic [RA-1:0]    id_rd, id_rs;
    logic [DW-1:0]    rf_a, rf_b, id_a, id_b_reg, id_b;
    logic             id_jmp;
    logic [PAW-1:0]   jmp_tgt;

    pp_regfile #(.DW(DW), .RN(RN)) u_regfile (
        .clk_i     (clk),
        .reset_i   (reset),
        .raddr_a_i (id_rd),
        .rdata_a_o (rf_a),
        .raddr_b_i (id_rs),
        .rdata_b_o (rf_b),
        .we_i      (wb_valid),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data)
    );

    assign imem_addr = pc_q;

    // ---- ID stage: decode, operand read with writeback forwarding ----
    always_comb begin
        instr_x  = MAX_W'(ifid_instr_q);
        id_op    = f_op(instr_x, RA);
        id_rd    = RA'(f_rd(instr_x, RA));
        id_rs    = RA'(f_rs(instr_x, RA));
        // The register being written this cycle is not yet in the file.
        id_a     = (wb_valid && wb_addr == id_rd) ? wb_data : rf_a;
        id_b_reg = (wb_valid && wb_addr == id_rs) ? wb_data : rf_b;
        id_b     = (id_op == OP_LI) ? DW'(sext(MAX_W'(id_rs), RA)) : id_b_reg;
        id_jmp   = ifid_vld_q && (id_op == OP_JMP);
        // Target is relative to the jump's own address: JMP 0 loops on itself.
        jmp_tgt  = PAW'(MAX_W'(ifid_pc_q) + sext(f_off(instr_x, RA), 2 * RA));
    end

    // ---- IF stage next state ----
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_vld_d   = 1'b0;
        if (id_jmp) begin
            // Redirect wins over a stalled fetch; the slot behind the jump is dropped.
            pc_d = jmp_tgt;
        end else if (imem_valid) begin
            ifid_instr_d = imem_data;
            ifid_pc_d    = pc_q;
            ifid_vld_d   = 1'b1;
            pc_d         = pc_q + PAW'(1);
        end
    end

    // ---- ID -> EX boundary ----
    always_comb begin
        idex_vld_d = ifid_vld_q;
        idex_op_d  = id_op;
        idex_rd_d  = id_rd;
        idex_a_d   = id_a;
        idex_b_d   = id_b;
    end

    // ---- EX/WB stage ----
    always_comb begin
        wb_valid = idex_vld_q && (idex_op_q != OP_JMP);
        wb_addr  = idex_rd_q;
        wb_data  = alu_fn(idex_op_q, idex_a_q, idex_b_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= '0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_vld_q   <= 1'b0;
            idex_op_q    <= OP_LI;
            idex_rd_q    <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            idex_vld_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_vld_q   <= ifid_vld_d;
            idex_op_q    <= idex_op_d;
            idex_rd_q    <= idex_rd_d;
            idex_a_q     <= idex_a_d;
            idex_b_q     <= idex_b_d;
            idex_vld_q   <= idex_vld_d;
        end
    end

endmodule

// File: tb/tb_pipe_proc_core.sv
module tb_pipe_proc_core;

    localparam int DW  = 8;
    localparam int RN  = 8;
    localparam int PAW = 8;
    localparam int RA  = 3;
    localparam int IW  = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           imem_valid = 1'b0;
    logic [PAW-1:0] imem_addr;
    logic [IW-1:0]  imem_data;
    logic           wb_valid;
    logic [RA-1:0]  wb_addr;
    logic [DW-1:0]  wb_data;

    logic [IW-1:0] mem [256];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [RA-1:0] a;
        logic [DW-1:0] d;
    } wb_t;
    wb_t exp_q[$];

    pipe_proc_core #(.DW(DW), .RN(RN), .PAW(PAW)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    always_comb imem_data = mem[imem_addr];

    // Scoreboard: every write the core announces must match the next expected one.
    always @(negedge clk) begin
        if (wb_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: got r%0d=%02h, required no write", wb_addr, wb_data);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if ({wb_addr, wb_data} !== e) begin
                    bad++;
                    $display("FAIL wb_check: got r%0d=%02h, required r%0d=%02h", wb_addr, wb_data, e.a, e.d);
                end
            end
        end
    end

    // ISA-level reference: sequential execution until a JMP 0 self-loop.
    task automatic model_run();
        logic [DW-1:0] r [RN];
        logic [IW-1:0] ins;
        logic [1:0]    op;
        logic [RA-1:0] rd, rs;
        logic [DW-1:0] v;
        int pc, sa, sb, res, off;
        for (int i = 0; i < RN; i++) r[i] = '0;
        pc = 0;
        for (int s = 0; s < 200; s++) begin
            ins = mem[pc];
            op  = ins[7:6];
            rd  = ins[5:3];
            rs  = ins[2:0];
            if (op == 2'b11) begin
                off = $signed(ins[5:0]);
                if (off == 0) break;
                pc = (pc + off) & 255;
            end else begin
                if (op == 2'b00) begin
                    sa = $signed(rs);
                    v  = sa[DW-1:0];
                end else begin
                    sa  = $signed(r[rd]);
                    sb  = $signed(r[rs]);
                    res = (op == 2'b01) ? sa + sb : sa - sb;
`ifdef SAT_ARITH_EN
                    if (res > (1 << (DW-1)) - 1) res = (1 << (DW-1)) - 1;
                    if (res < -(1 << (DW-1)))    res = -(1 << (DW-1));
`endif
                    v = res[DW-1:0];
                end
                r[rd] = v;
                exp_q.push_back({rd, v});
                pc = (pc + 1) & 255;
            end
        end
    endtask

    task automatic begin_reset();
        @(negedge clk);
        reset      = 1'b1;
        imem_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
        exp_q.delete();
    endtask

    task automatic release_run(input bit use_model);
        if (use_model) model_run();
        imem_valid = 1'b1;
        reset      = 1'b0;
    endtask

    task automatic test_reset();
        begin_reset();
        total++;
        if ({wb_valid, wb_addr, wb_data} !== '0) begin
            bad++;
            $display("FAIL reset_wb: got v=%0b a=%0d d=%02h, required all zero", wb_valid, wb_addr, wb_data);
        end
        total++;
        if (imem_addr !== 8'h00) begin
            bad++;
            $display("FAIL reset_pc: got %02h, required 00", imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mask;
        begin_reset();
        mem[0] = 8'h0B; mem[1] = 8'h16; mem[2] = 8'h4A;
        exp_q.push_back({3'd1, 8'h03});
        exp_q.push_back({3'd2, 8'hFE});
        exp_q.push_back({3'd1, 8'h01});
        release_run(1'b0);
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mask[i] = wb_valid;
        end
        total++;
        if (mask !== 8'b0000_1110) begin
            bad++;
            $display("FAIL b2b_timing: got wb mask %08b, required 00001110", mask);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_missing: got %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_jump();
        logic [7:0] exp_a [10];
        exp_a = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd6, 8'd7, 8'd6, 8'd7};
        begin_reset();
        mem[0] = 8'h09; mem[1] = 8'h12; mem[2] = 8'hC4; mem[3] = 8'h1B;
        mem[6] = 8'hC0; mem[7] = 8'h39;
        release_run(1'b1);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (imem_addr !== exp_a[i]) begin
                bad++;
                $display("FAIL jmp_fetch[%0d]: got %0d, required %0d", i, imem_addr, exp_a[i]);
            end
            @(negedge clk);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL jmp_missing: got %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        logic [7:0] mask;
        begin_reset();
        mem[0] = 8'h19; mem[1] = 8'h5B;
        release_run(1'b1);
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mask[i] = wb_valid;
            if (i < 3) begin
                total++;
                if (imem_addr !== 8'd1) begin
                    bad++;
                    $display("FAIL stall_pc[%0d]: got %0d, required 1", i, imem_addr);
                end
            end
            imem_valid = (i >= 2);
        end
        total++;
        if (mask !== 8'b0001_0010) begin
            bad++;
            $display("FAIL stall_timing: got wb mask %08b, required 00010010", mask);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL stall_missing: got %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_arith();
        logic [7:0] prog [23];
        prog = '{8'h23, 8'h64, 8'h64, 8'h29, 8'hA5, 8'h32, 8'h76, 8'h76, 8'h76, 8'h76,
                 8'h76, 8'h7E, 8'hB5, 8'h77, 8'h75, 8'h04, 8'h40, 8'h40, 8'h40, 8'h40,
                 8'h40, 8'h85, 8'hC0};
        begin_reset();
        for (int i = 0; i < 23; i++) mem[i] = prog[i];
        exp_q.push_back({3'd4, 8'h03}); exp_q.push_back({3'd4, 8'h06});
        exp_q.push_back({3'd4, 8'h0C}); exp_q.push_back({3'd5, 8'h01});
        exp_q.push_back({3'd4, 8'h0B}); exp_q.push_back({3'd6, 8'h02});
        exp_q.push_back({3'd6, 8'h04}); exp_q.push_back({3'd6, 8'h08});
        exp_q.push_back({3'd6, 8'h10}); exp_q.push_back({3'd6, 8'h20});
        exp_q.push_back({3'd6, 8'h40}); exp_q.push_back({3'd7, 8'h40});
        exp_q.push_back({3'd6, 8'h3F}); exp_q.push_back({3'd6, 8'h7F});
`ifdef SAT_ARITH_EN
        exp_q.push_back({3'd6, 8'h7F});
`else
        exp_q.push_back({3'd6, 8'h80});
`endif
        exp_q.push_back({3'd0, 8'hFC}); exp_q.push_back({3'd0, 8'hF8});
        exp_q.push_back({3'd0, 8'hF0}); exp_q.push_back({3'd0, 8'hE0});
        exp_q.push_back({3'd0, 8'hC0}); exp_q.push_back({3'd0, 8'h80});
`ifdef SAT_ARITH_EN
        exp_q.push_back({3'd0, 8'h80});
`else
        exp_q.push_back({3'd0, 8'h7F});
`endif
        release_run(1'b0);
        for (int i = 0; i < 30; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL arith_missing: got %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        begin_reset();
        mem[0] = 8'h0B; mem[1] = 8'h49;
        exp_q.push_back({3'd1, 8'h03});
        release_run(1'b0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        total++;
        if (wb_valid !== 1'b1 || wb_data !== 8'h06) begin
            bad++;
            $display("FAIL rstmid_add_in_ex: got v=%0b d=%02h, required v=1 d=06", wb_valid, wb_data);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if ({wb_valid, wb_addr, wb_data} !== '0) begin
            bad++;
            $display("FAIL rstmid_wb_drop: got v=%0b a=%0d d=%02h, required all zero", wb_valid, wb_addr, wb_data);
        end
        @(negedge clk);
        for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
        exp_q.delete();
        for (int i = 0; i < RN; i++) begin
            mem[i] = {2'b01, 3'(i), 3'(i)};
            exp_q.push_back({3'(i), 8'h00});
        end
        release_run(1'b0);
        total++;
        if (imem_addr !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_pc: got %02h, required 00", imem_addr);
        end
        for (int i = 0; i < 14; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rstmid_missing: got %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_jmp_stall();
        begin_reset();
        mem[0] = 8'h09; mem[1] = 8'hC3; mem[2] = 8'h11; mem[3] = 8'h13;
        mem[4] = 8'h1A; mem[5] = 8'hC0;
        release_run(1'b1);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (imem_addr !== 8'd2) begin
            bad++;
            $display("FAIL jstall_pc_before: got %0d, required 2", imem_addr);
        end
        imem_valid = 1'b0;
        @(negedge clk);
        total++;
        if (imem_addr !== 8'd4) begin
            bad++;
            $display("FAIL jstall_target: got %0d, required 4", imem_addr);
        end
        imem_valid = 1'b1;
        @(negedge clk);
        total++;
        if (imem_addr !== 8'd5) begin
            bad++;
            $display("FAIL jstall_next: got %0d, required 5", imem_addr);
        end
        for (int i = 0; i < 10; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL jstall_missing: got %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_jump();
        test_stall();
        test_arith();
        test_reset_mid();
        test_jmp_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
